branch_resolve_unit: RTL and testbench

- Consumes the eq/ls/lu flags produced by the comparator and turns them into a registered branch decision for the execute stage.
- Decodes RV64 branch funct3 and computes the target and fall-through PCs.
- Compares the decision against the fetch prediction and raises a redirect on mispredict.
- Single-entry valid/ready pipeline stage with flush, plus saturating performance counters.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_decide.sv | 47 ++++
 rtl/branch_resolve_unit.sv | 93 +++++++++
 tb/tb_branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for branch resolution: funct3 encodings, PC increment, result record.
// No logic; constants and typedefs only.
// No handshake; consumed by branch_decide and branch_resolve_unit.
package branch_pkg;

    localparam int BR_XLEN = 64;
    localparam int PC_INC  = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_t;

    // next_pc is sized for the widest supported PC; narrower cores zero-extend.
    typedef struct packed {
        logic               taken;
        logic [BR_XLEN-1:0] next_pc;
        logic               mispredict;
        logic               illegal;
    } br_result_t;

endpackage

// File: rtl/branch_decide.sv
// Maps funct3 plus comparator flags to direction, next PC and mispredict.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage decides when the result is captured.
module branch_decide
    import branch_pkg::*;
#(
    parameter int XLEN = BR_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic            eq,
    input  logic            ls,
    input  logic            lu,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output br_result_t      result
);

    logic            cond;
    logic            legal;
    logic            taken_c;
    logic [XLEN-1:0] target;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            BEQ:     cond = eq;
            BNE:     cond = !eq;
            BLT:     cond = ls;
            BGE:     cond = !ls;
            BLTU:    cond = lu;
            BGEU:    cond = !lu;
            default: legal = 1'b0;
        endcase
        taken_c = legal && cond;
        // Modulo-2^XLEN adds: wrap past the top of the address space is intentional.
        target  = taken_c ? (pc + imm) : (pc + XLEN'(PC_INC));

        result            = '0;
        result.taken      = taken_c;
        result.next_pc    = BR_XLEN'(target);
        result.mispredict = legal && (taken_c != pred_taken);
        result.illegal    = !legal;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Single-entry branch resolution stage with mispredict detection and saturating counters.
// Latency: 1 cycle from accept to out_valid; 1 branch/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; flush overrides both hold and accept.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic             eq,
    input  logic             ls,
    input  logic             lu,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  next_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] n_branches,
    output logic [CNT_W-1:0] n_mispredicts
);

    br_result_t       res_d;
    br_result_t       res_q;
    logic             valid_q;
    logic             accept;
    logic [CNT_W-1:0] n_br_d, n_br_q;
    logic [CNT_W-1:0] n_mp_d, n_mp_q;

    branch_decide #(.XLEN(XLEN)) u_decide (
        .funct3     (funct3),
        .eq         (eq),
        .ls         (ls),
        .lu         (lu),
        .pc         (pc),
        .imm        (imm),
        .pred_taken (pred_taken),
        .result     (res_d)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        n_br_d = n_br_q;
        n_mp_d = n_mp_q;
        // Illegal encodings are reported downstream but never counted as branches.
        if (accept && !res_d.illegal) begin
            if (n_br_q != '1)
                n_br_d = n_br_q + CNT_W'(1);
            if (res_d.mispredict && (n_mp_q != '1))
                n_mp_d = n_mp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            n_br_q  <= '0;
            n_mp_q  <= '0;
        end else begin
            n_br_q <= n_br_d;
            n_mp_q <= n_mp_d;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                res_q   <= res_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = valid_q;
    assign taken         = res_q.taken;
    assign next_pc       = res_q.next_pc[XLEN-1:0];
    assign mispredict    = res_q.mispredict;
    assign illegal       = res_q.illegal;
    assign n_branches    = n_br_q;
    assign n_mispredicts = n_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench with a scoreboard queue; a narrow-counter twin instance exercises saturation.
module tb_branch_resolve_unit;

    typedef struct {
        logic [2:0]  f3;
        logic        eq, ls, lu;
        logic [63:0] pc, imm;
        logic        pred;
        logic        taken;
        logic [63:0] npc;
        logic        mp;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [63:0] npc;
        logic        mp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, s_in_ready;
    logic [2:0]  funct3;
    logic        eq, ls, lu, pred_taken, flush, out_ready;
    logic [63:0] pc, imm;
    logic        out_valid, taken, mispredict, illegal;
    logic [63:0] next_pc;
    logic [31:0] n_branches, n_mispredicts;
    logic        s_out_valid, s_taken, s_mispredict, s_illegal;
    logic [63:0] s_next_pc;
    logic [1:0]  s_nb, s_nm;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .eq(eq), .ls(ls), .lu(lu), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .taken(taken), .next_pc(next_pc),
        .mispredict(mispredict), .illegal(illegal),
        .n_branches(n_branches), .n_mispredicts(n_mispredicts)
    );

    branch_resolve_unit #(.XLEN(64), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .funct3(funct3), .eq(eq), .ls(ls), .lu(lu), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .taken(s_taken), .next_pc(s_next_pc),
        .mispredict(s_mispredict), .illegal(s_illegal),
        .n_branches(s_nb), .n_mispredicts(s_nm)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        cur_exp;
    int unsigned exp_nb = 0, exp_nm = 0, exp_nb_s = 0, exp_nm_s = 0;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic e, input logic l, input logic u,
                                input logic [63:0] p, input logic [63:0] i, input logic pr,
                                input logic t, input logic [63:0] n, input logic m, input logic il);
        vec_t v;
        v.f3 = f3; v.eq = e; v.ls = l; v.lu = u; v.pc = p; v.imm = i; v.pred = pr;
        v.taken = t; v.npc = n; v.mp = m; v.ill = il;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        funct3     = v.f3;
        eq         = v.eq;
        ls         = v.ls;
        lu         = v.lu;
        pc         = v.pc;
        imm        = v.imm;
        pred_taken = v.pred;
        cur_exp.taken = v.taken;
        cur_exp.npc   = v.npc;
        cur_exp.mp    = v.mp;
        cur_exp.ill   = v.ill;
    endtask

    // One clock: score the handshake the bench expects, advance, then check visible state.
    task automatic tick();
        bit   acc, cons;
        exp_t e;
        #2;
        acc  = in_valid && (q.size() == 0 || out_ready) && !flush;
        cons = (q.size() != 0) && out_ready && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (cons) begin
                e = q.pop_front();
                chk("taken", {63'b0, taken}, {63'b0, e.taken});
                chk("next_pc", next_pc, e.npc);
                chk("mispredict", {63'b0, mispredict}, {63'b0, e.mp});
                chk("illegal", {63'b0, illegal}, {63'b0, e.ill});
                chk("s_taken", {63'b0, s_taken}, {63'b0, e.taken});
                chk("s_next_pc", s_next_pc, e.npc);
                chk("s_mispredict", {63'b0, s_mispredict}, {63'b0, e.mp});
                chk("s_illegal", {63'b0, s_illegal}, {63'b0, e.ill});
            end
            if (acc) begin
                q.push_back(cur_exp);
                if (!cur_exp.ill) begin
                    exp_nb++;
                    if (exp_nb_s < 3) exp_nb_s++;
                    if (cur_exp.mp) begin
                        exp_nm++;
                        if (exp_nm_s < 3) exp_nm_s++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
        chk("s_out_valid", {63'b0, s_out_valid}, {63'b0, q.size() != 0});
        chk("in_ready", {63'b0, in_ready}, {63'b0, (q.size() == 0) || out_ready});
        chk("s_in_ready", {63'b0, s_in_ready}, {63'b0, (q.size() == 0) || out_ready});
        chk("n_branches", {32'b0, n_branches}, 64'(exp_nb));
        chk("n_mispredicts", {32'b0, n_mispredicts}, 64'(exp_nm));
        chk("s_n_branches", {62'b0, s_nb}, 64'(exp_nb_s));
        chk("s_n_mispredicts", {62'b0, s_nm}, 64'(exp_nm_s));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(3'b000, 1, 0, 0, 64'h1000, 64'h20, 0, 1, 64'h1020, 1, 0);
        tbl[1]  = mk(3'b111, 0, 0, 1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h2004, 0, 0);
        tbl[2]  = mk(3'b001, 0, 0, 0, 64'h3000, 64'h100, 1, 1, 64'h3100, 0, 0);
        tbl[3]  = mk(3'b001, 1, 0, 0, 64'h3000, 64'h100, 1, 0, 64'h3004, 1, 0);
        tbl[4]  = mk(3'b100, 0, 1, 0, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 64'h3FF0, 0, 0);
        tbl[5]  = mk(3'b101, 0, 1, 0, 64'h5000, 64'h40, 1, 0, 64'h5004, 1, 0);
        tbl[6]  = mk(3'b101, 1, 0, 1, 64'h5000, 64'h40, 0, 1, 64'h5040, 1, 0);
        tbl[7]  = mk(3'b110, 0, 0, 1, 64'h6000, 64'h8, 1, 1, 64'h6008, 0, 0);
        tbl[8]  = mk(3'b111, 0, 1, 0, 64'h7000, 64'h10, 1, 1, 64'h7010, 0, 0);
        tbl[9]  = mk(3'b010, 1, 1, 1, 64'h8000, 64'h20, 1, 0, 64'h8004, 0, 1);
        tbl[10] = mk(3'b011, 0, 0, 0, 64'h9000, 64'h20, 0, 0, 64'h9004, 0, 1);
        tbl[11] = mk(3'b000, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, 0, 64'h0, 0, 0);

        rst_n = 1'b0; in_valid = 1'b0; funct3 = 3'b0; eq = 1'b0; ls = 1'b0; lu = 1'b0;
        pc = '0; imm = '0; pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cur_exp = '{1'b0, 64'h0, 1'b0, 1'b0};
        #12;
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_taken", {63'b0, taken}, 64'h0);
        chk("rst_next_pc", next_pc, 64'h0);
        chk("rst_mispredict", {63'b0, mispredict}, 64'h0);
        chk("rst_illegal", {63'b0, illegal}, 64'h0);
        chk("rst_n_branches", {32'b0, n_branches}, 64'h0);
        chk("rst_n_mispredicts", {32'b0, n_mispredicts}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream with the sink always ready.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            tick();
        end
        idle(); tick();
        chk("table_n_branches", {32'b0, n_branches}, 64'd10);
        chk("table_n_mispredicts", {32'b0, n_mispredicts}, 64'd4);

        // Hold a BLT for three cycles with a BNE waiting, then release with no bubble.
        out_ready = 1'b0;
        drive(mk(3'b100, 0, 1, 0, 64'hA000, 64'h20, 0, 1, 64'hA020, 1, 0));
        tick();
        drive(mk(3'b001, 0, 0, 0, 64'hB000, 64'h4, 1, 1, 64'hB004, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_in_ready", {63'b0, in_ready}, 64'h0);
            chk("hold_taken", {63'b0, taken}, 64'h1);
            chk("hold_next_pc", next_pc, 64'hA020);
            chk("hold_mispredict", {63'b0, mispredict}, 64'h1);
        end
        out_ready = 1'b1;
        tick();
        chk("b2b_out_valid", {63'b0, out_valid}, 64'h1);
        chk("b2b_next_pc", next_pc, 64'hB004);
        idle(); tick();

        // Flush a held result together with an incoming request.
        out_ready = 1'b0;
        drive(mk(3'b000, 1, 0, 0, 64'hC000, 64'h8, 1, 1, 64'hC008, 0, 0));
        tick();
        drive(mk(3'b000, 1, 0, 0, 64'hC100, 64'h8, 0, 1, 64'hC108, 1, 0));
        flush = 1'b1;
        tick();
        chk("flush_out_valid", {63'b0, out_valid}, 64'h0);
        chk("flush_n_branches", {32'b0, n_branches}, 64'd13);
        flush = 1'b0; out_ready = 1'b1;
        drive(mk(3'b110, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 1, 64'h4, 0, 0));
        tick();
        idle(); tick();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        drive(mk(3'b001, 0, 0, 0, 64'hD000, 64'h10, 0, 1, 64'hD010, 1, 0));
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("arst_n_branches", {32'b0, n_branches}, 64'h0);
        chk("arst_n_mispredicts", {32'b0, n_mispredicts}, 64'h0);
        chk("arst_s_n_branches", {62'b0, s_nb}, 64'h0);
        q.delete();
        exp_nb = 0; exp_nm = 0; exp_nb_s = 0; exp_nm_s = 0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Saturation on the narrow-counter twin: five mispredicts, counters pin at 3.
        for (int i = 0; i < 5; i++) begin
            drive(mk(3'b000, 1, 0, 0, 64'hE000, 64'h10, 0, 1, 64'hE010, 1, 0));
            tick();
        end
        idle(); tick();
        chk("sat_s_n_branches", {62'b0, s_nb}, 64'd3);
        chk("sat_s_n_mispredicts", {62'b0, s_nm}, 64'd3);
        chk("sat_n_branches", {32'b0, n_branches}, 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
